// File: rtl/age_issue_queue.sv
// rtl/age_issue_queue.sv - age-ordered issue queue with wakeup, bypass, flush and registered issue port
module age_issue_queue #(
   parameter int INST_ID_BITS = 6,
   parameter int PRN_BITS     = 6,
   parameter int NUM_OPS      = 3,
   parameter int QUEUE_SIZE   = 8,
   parameter int WAKE_PORTS   = 4,
   parameter int IN_ORDER     = 0
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      flush,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [INST_ID_BITS-1:0]   in_inst_id,
   input  logic [31:0]               in_inst,
   input  logic [63:0]               in_pc,
   input  logic                      in_op_valid [NUM_OPS],
   input  logic                      in_op_ready [NUM_OPS],
   input  logic [PRN_BITS-1:0]       in_op_prn [NUM_OPS],
   input  logic [PRN_BITS-1:0]       in_out_prn [NUM_OPS],
   input  logic                      wake_valid [WAKE_PORTS],
   input  logic [PRN_BITS-1:0]       wake_prn [WAKE_PORTS],
   output logic                      prf_read_en [NUM_OPS],
   output logic [PRN_BITS-1:0]       prf_read_prn [NUM_OPS],
   input  logic [63:0]               prf_data [NUM_OPS],
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [INST_ID_BITS-1:0]   out_inst_id,
   output logic [31:0]               out_inst,
   output logic [63:0]               out_pc,
   output logic [63:0]               out_op [NUM_OPS],
   output logic [PRN_BITS-1:0]       out_out_prn [NUM_OPS],
   output logic [$clog2(QUEUE_SIZE):0] occupancy
);
   localparam int AGE_W = $clog2(QUEUE_SIZE);
   localparam int CNT_W = AGE_W + 1;

   logic                    valid_q    [QUEUE_SIZE];
   logic [AGE_W-1:0]        age_q      [QUEUE_SIZE];
   logic [INST_ID_BITS-1:0] inst_id_q  [QUEUE_SIZE];
   logic [31:0]             inst_q     [QUEUE_SIZE];
   logic [63:0]             pc_q       [QUEUE_SIZE];
   logic [NUM_OPS-1:0]      op_valid_q [QUEUE_SIZE];
   logic [NUM_OPS-1:0]      op_ready_q [QUEUE_SIZE];
   logic [PRN_BITS-1:0]     op_prn_q   [QUEUE_SIZE][NUM_OPS];
   logic [PRN_BITS-1:0]     out_prn_q  [QUEUE_SIZE][NUM_OPS];

   logic [NUM_OPS-1:0]      op_wake    [QUEUE_SIZE];
   logic [NUM_OPS-1:0]      in_wake;
   logic [QUEUE_SIZE-1:0]   ent_ready;
   logic                    sel_valid;
   logic [AGE_W-1:0]        sel_idx;
   logic [AGE_W-1:0]        sel_age;
   logic                    free_found;
   logic [AGE_W-1:0]        free_idx;
   logic [CNT_W-1:0]        cnt;
   logic                    issue_fire;
   logic                    ins_fire;

   // Compare every stored and incoming operand against every wakeup port
   always_comb begin
      in_wake = '0;
      for (int q = 0; q < QUEUE_SIZE; q++) op_wake[q] = '0;
      for (int p = 0; p < WAKE_PORTS; p++) begin
         for (int i = 0; i < NUM_OPS; i++) begin
            if (wake_valid[p] && wake_prn[p] == in_op_prn[i]) in_wake[i] = 1'b1;
            for (int q = 0; q < QUEUE_SIZE; q++)
               if (wake_valid[p] && wake_prn[p] == op_prn_q[q][i]) op_wake[q][i] = 1'b1;
         end
      end
   end

   // Occupancy, lowest free slot and per-entry readiness from registered state
   always_comb begin
      cnt        = '0;
      free_found = 1'b0;
      free_idx   = '0;
      ent_ready  = '0;
      for (int q = 0; q < QUEUE_SIZE; q++) begin
         if (valid_q[q]) cnt = cnt + CNT_W'(1);
         if (!valid_q[q] && !free_found) begin
            free_found = 1'b1;
            free_idx   = AGE_W'(q);
         end
         ent_ready[q] = valid_q[q] && (&(op_ready_q[q] | ~op_valid_q[q]));
      end
   end

   // Pick the oldest ready entry, or only the age-0 entry in in-order mode
   always_comb begin
      sel_valid = 1'b0;
      sel_idx   = '0;
      sel_age   = '0;
      for (int q = 0; q < QUEUE_SIZE; q++) begin
         if (ent_ready[q]) begin
            if (IN_ORDER != 0) begin
               if (age_q[q] == '0) begin
                  sel_valid = 1'b1;
                  sel_idx   = AGE_W'(q);
                  sel_age   = '0;
               end
            end else if (!sel_valid || age_q[q] < sel_age) begin
               sel_valid = 1'b1;
               sel_idx   = AGE_W'(q);
               sel_age   = age_q[q];
            end
         end
      end
   end

   // Handshake qualifiers and the combinational PRF read port
   always_comb begin
      in_ready   = free_found;
      occupancy  = cnt;
      ins_fire   = in_valid && free_found && !flush;
      issue_fire = sel_valid && (!out_valid || out_ready) && !flush;
      for (int i = 0; i < NUM_OPS; i++) begin
         prf_read_en[i]  = sel_valid && op_valid_q[sel_idx][i];
         prf_read_prn[i] = sel_valid ? op_prn_q[sel_idx][i] : '0;
      end
   end

   // Entry storage, age maintenance and the issue output register
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int q = 0; q < QUEUE_SIZE; q++) begin
            valid_q[q]    <= 1'b0;
            age_q[q]      <= '0;
            inst_id_q[q]  <= '0;
            inst_q[q]     <= '0;
            pc_q[q]       <= '0;
            op_valid_q[q] <= '0;
            op_ready_q[q] <= '0;
            for (int i = 0; i < NUM_OPS; i++) begin
               op_prn_q[q][i]  <= '0;
               out_prn_q[q][i] <= '0;
            end
         end
         out_valid   <= 1'b0;
         out_inst_id <= '0;
         out_inst    <= '0;
         out_pc      <= '0;
         for (int i = 0; i < NUM_OPS; i++) begin
            out_op[i]      <= '0;
            out_out_prn[i] <= '0;
         end
      end else if (flush) begin
         for (int q = 0; q < QUEUE_SIZE; q++) begin
            valid_q[q] <= 1'b0;
            age_q[q]   <= '0;
         end
         out_valid <= 1'b0;
      end else begin
         for (int q = 0; q < QUEUE_SIZE; q++) begin
            if (valid_q[q]) op_ready_q[q] <= op_ready_q[q] | (op_valid_q[q] & op_wake[q]);
            if (issue_fire && valid_q[q] && age_q[q] > sel_age) age_q[q] <= age_q[q] - AGE_W'(1);
         end
         if (issue_fire) begin
            valid_q[sel_idx] <= 1'b0;
            age_q[sel_idx]   <= '0;
            out_valid        <= 1'b1;
            out_inst_id      <= inst_id_q[sel_idx];
            out_inst         <= inst_q[sel_idx];
            out_pc           <= pc_q[sel_idx];
            for (int i = 0; i < NUM_OPS; i++) begin
               out_op[i]      <= op_valid_q[sel_idx][i] ? prf_data[i] : 64'd0;
               out_out_prn[i] <= out_prn_q[sel_idx][i];
            end
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
         if (ins_fire) begin
            valid_q[free_idx]   <= 1'b1;
            age_q[free_idx]     <= AGE_W'(cnt - CNT_W'(issue_fire));
            inst_id_q[free_idx] <= in_inst_id;
            inst_q[free_idx]    <= in_inst;
            pc_q[free_idx]      <= in_pc;
            for (int i = 0; i < NUM_OPS; i++) begin
               op_valid_q[free_idx][i] <= in_op_valid[i];
               op_ready_q[free_idx][i] <= in_op_ready[i] | in_wake[i];
               op_prn_q[free_idx][i]   <= in_op_prn[i];
               out_prn_q[free_idx][i]  <= in_out_prn[i];
            end
         end
      end
   end
endmodule

// File: doc/age_issue_queue.md
# age_issue_queue

Parametrised, age-ordered issue queue between the renamer and one functional unit. Holds up to QUEUE_SIZE renamed instructions and tracks operand readiness from WAKE_PORTS broadcast wakeup ports. It issues the oldest ready entry, or only the oldest entry in IN_ORDER mode, through a valid/ready output register that also captures PRF operand data. Adds over the previous generation: true age ordering, any-slot wakeup matching, insert-cycle wakeup bypass, output backpressure, full flush, and an occupancy count.

## Interface
Parameters:
- INST_ID_BITS, 6, instruction ID width
- PRN_BITS, 6, physical register number width
- NUM_OPS, 3, operand/destination slots per instruction
- QUEUE_SIZE, 8, entries; power of 2, ≥2
- WAKE_PORTS, 4, wakeup broadcast ports
- IN_ORDER, 0, 1 = issue only the oldest entry

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- flush  in  1  discard all contents
- in_valid / in_ready  in / out  1  insert handshake
- in_inst_id  in  INST_ID_BITS  instruction ID
- in_inst  in  32  raw instruction
- in_pc  in  64  PC
- in_op_valid[NUM_OPS], in_op_ready[NUM_OPS]  in  1 each  operand used / already in PRF
- in_op_prn[NUM_OPS], in_out_prn[NUM_OPS]  in  PRN_BITS each  source / destination PRNs
- wake_valid[WAKE_PORTS]  in  1 each  broadcast valid
- wake_prn[WAKE_PORTS]  in  PRN_BITS each  PRN becoming ready
- prf_read_en[NUM_OPS]  out  1 each  combinational PRF read enable
- prf_read_prn[NUM_OPS]  out  PRN_BITS each  combinational PRF read address
- prf_data[NUM_OPS]  in  64 each  PRF read data, same cycle
- out_valid / out_ready  out / in  1  issue handshake to FU
- out_inst_id, out_inst, out_pc, out_op[NUM_OPS], out_out_prn[NUM_OPS]  out  widths as above (out_op 64)  issued instruction
- occupancy  out  $clog2(QUEUE_SIZE)+1  valid entry count

## Operation
- Entry state: valid, age, inst_id, inst, pc, and per-slot op_valid, op_ready, op_prn, out_prn.
- Age: 0 is oldest. Valid entries always hold distinct ages 0..occupancy-1.
- Insert fires when in_valid && in_ready && !flush.
  - Target is the lowest-index free slot.
  - New entry age = occupancy − (1 if an issue fires in the same cycle, else 0).
- in_ready = any slot free in the registered state. An issue in the same cycle does not raise in_ready.
- Wakeup: an operand sets op_ready when op_valid and any wake port has wake_valid && wake_prn == op_prn. Every operand slot is compared against every port.
- Insert bypass: an inserted operand is stored ready if in_op_ready, or if it matches any wake port in the insert cycle.
- Entry ready: valid && (op_ready | ~op_valid) all ones.
- Selection:
  - IN_ORDER=0: the ready entry with the smallest age.
  - IN_ORDER=1: the age-0 entry, only if it is ready.
- Issue fires when a selected entry exists && (!out_valid || out_ready) && !flush. At that edge:
  - The output register loads the entry fields.
  - out_op[i] = prf_data[i] if op_valid[i], else 0.
  - The entry is cleared.
  - Entries older than it keep their age; younger entries decrement age by 1.
- prf_read_en[i] = selected && op_valid[i]; prf_read_prn[i] = op_prn[i]. Both are 0 when nothing is selected.
- Output register: out_valid stays set with stable data until out_ready. On a handshake with no new issue, out_valid clears.
- Flush: at the edge, all entries are invalidated and out_valid clears. The same-cycle insert and issue are suppressed.

## Timing
- Reset values:
  - All entries invalid, ages 0.
  - out_valid=0; all out_* data fields 0.
  - occupancy=0; in_ready=1 from the first cycle after reset.
  - prf_read_en all 0.
- Insert accepted at edge E → entry visible and selectable in cycle E+1 → earliest out_valid after edge E+1.
- Wakeup at edge W on a waiting entry → selectable in cycle W+1.
- Full queue: in_ready=0; an issue in that cycle frees the slot for the next cycle only.
- Empty queue: no selection, prf_read_en all 0, out_valid unchanged until handshake.
- Back-to-back: with out_ready held 1, one issue per cycle.
- Simultaneous insert and issue: both take effect; occupancy unchanged.
- Wakeup on the issue edge of the same entry: no effect, the entry is cleared.
- rst has priority over flush, and flush over all other operations.

## Test plan
- Reset, then insert 3 entries with all operands ready (IDs 1,2,3), out_ready=1 → out_inst_id 1,2,3 on consecutive cycles; occupancy returns to 0.
- OOO mode: insert ID 5 waiting on PRN 9, then ID 6 ready → 6 issues first. wake_prn=9 → 5 issues next with out_op[0] = prf_data[0] sampled at issue.
- IN_ORDER=1, same stimulus → nothing issues until the PRN 9 wakeup; then 5 issues, then 6.
- Fill QUEUE_SIZE entries → in_ready=0, occupancy=8. One issue → in_ready=1 the next cycle; insert a ninth entry that is not yet ready → its age = 7 and it issues last.
- Insert an operand waiting on PRN 12 in the same cycle as wake_prn=12 → the entry issues after the next edge. Hold out_ready=0 for 3 cycles → out_* stable, out_valid=1 throughout.
- With 4 entries and out_valid=1, pulse flush alongside in_valid → occupancy=0, out_valid=0, the new instruction is not stored, and in_ready=1 the next cycle.
